spi_slave_regif: RTL and testbench

SPI mode-0 slave protocol engine that sits directly downstream of the SPI pin synchroniser. It consumes the synchronised strobes (frame reset, SCK-rising sample, SCK-falling shift) and the synchronised MOSI bit. It deframes bytes into a command/address byte followed by a burst of data bytes with address auto-increment. It drives a single-cycle register-bus interface and returns read data on MISO, MSB first.

---
 rtl/spi_slave_regif_if.sv | 21 ++
 rtl/spi_slave_regif.sv | 125 ++++++++++++
 tb/tb_spi_slave_regif.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regif_if.sv
// Register-bus bundle between the SPI slave protocol engine and a register file.
// The engine is the master; read data returns one clock after reg_re.
interface spi_slave_regif_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave engine: deframes cmd/addr + data bytes from synchronised strobes,
// drives a single-cycle register bus with address auto-increment, returns reads on MISO.
module spi_slave_regif #(
    parameter int         ADDR_W = 7,
    parameter logic [7:0] STATUS = 8'hA5
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      spi_reset,
    input  logic                      spi_read,
    input  logic                      spi_write,
    input  logic                      mosi_in,
    output logic                      miso,
    output logic                      frame_active,
    spi_slave_regif_if.master         bus
);

    typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_t;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_shift, tx_shift, rd_buf;
    logic [7:0]        rx_next, tx_next;
    logic [ADDR_W-1:0] addr;
    logic              byte_done;
    logic              addr_inc_p1, rd_req_p1, rd_cap_p2;

    function automatic logic [ADDR_W-1:0] addr_plus1(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        byte_done = 1'b0;
        rx_next   = {rx_shift[6:0], mosi_in};
        // First falling edge of a byte loads the next byte; later ones shift.
        if (bit_cnt == 3'd0)
            tx_next = (state_q == RD_DATA) ? rd_buf : 8'h00;
        else
            tx_next = {tx_shift[6:0], 1'b0};
        if (spi_reset) begin
            state_d = CMD;
        end else if (spi_read && state_q != IDLE) begin
            byte_done = (bit_cnt == 3'd7);
            if (byte_done && state_q == CMD)
                state_d = rx_next[7] ? RD_DATA : WR_DATA;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            miso          <= 1'b0;
            frame_active  <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= 8'h00;
            bus.reg_we    <= 1'b0;
            bus.reg_re    <= 1'b0;
            bit_cnt       <= 3'd0;
            rx_shift      <= 8'h00;
            tx_shift      <= 8'h00;
            rd_buf        <= 8'h00;
            addr          <= '0;
            addr_inc_p1   <= 1'b0;
            rd_req_p1     <= 1'b0;
            rd_cap_p2     <= 1'b0;
        end else begin
            bus.reg_we  <= 1'b0;
            bus.reg_re  <= 1'b0;
            addr_inc_p1 <= 1'b0;
            rd_req_p1   <= 1'b0;
            // Stage p1: deferred address bump / burst read request
            if (addr_inc_p1) addr <= addr_plus1(addr);
            if (rd_req_p1) begin
                bus.reg_re   <= 1'b1;
                bus.reg_addr <= addr;
            end
            // Stage p2: read data arrives one clock after the strobe
            rd_cap_p2 <= bus.reg_re;
            if (rd_cap_p2) rd_buf <= bus.reg_rdata;

            if (spi_reset) begin
                frame_active <= 1'b1;
                bit_cnt      <= 3'd0;
                rx_shift     <= 8'h00;
                tx_shift     <= STATUS;
                miso         <= STATUS[7];
                bus.reg_re   <= 1'b0;
            end else if (spi_read && state_q != IDLE) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
                if (byte_done) begin
                    case (state_q)
                        CMD: begin
                            addr <= rx_next[ADDR_W-1:0];
                            if (rx_next[7]) begin
                                bus.reg_re   <= 1'b1;
                                bus.reg_addr <= rx_next[ADDR_W-1:0];
                            end
                        end
                        WR_DATA: begin
                            bus.reg_we    <= 1'b1;
                            bus.reg_wdata <= rx_next;
                            bus.reg_addr  <= addr;
                            addr_inc_p1   <= 1'b1;
                        end
                        RD_DATA: begin
                            addr      <= addr_plus1(addr);
                            rd_req_p1 <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (spi_write && state_q != IDLE) begin
                tx_shift <= tx_next;
                miso     <= tx_next[7];
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: write/read bursts, wrap, abort, async reset, idle strobes.
module tb_spi_slave_regif;

    logic clk       = 1'b0;
    logic nrst      = 1'b0;
    logic spi_reset = 1'b0;
    logic spi_read  = 1'b0;
    logic spi_write = 1'b0;
    logic mosi_in   = 1'b0;
    logic miso;
    logic frame_active;

    int checks = 0;
    int errors = 0;

    logic [15:0] we_q[$];
    logic [6:0]  re_q[$];

    spi_slave_regif_if #(.ADDR_W(7)) bus ();

    spi_slave_regif #(.ADDR_W(7), .STATUS(8'hA5)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .spi_reset    (spi_reset),
        .spi_read     (spi_read),
        .spi_write    (spi_write),
        .mosi_in      (mosi_in),
        .miso         (miso),
        .frame_active (frame_active),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Register file model: registered read returning addr + 0x40
    always @(posedge clk) begin
        if (bus.reg_re) bus.reg_rdata <= {1'b0, bus.reg_addr} + 8'h40;
    end

    always @(negedge clk) begin
        if (bus.reg_we) we_q.push_back({1'b0, bus.reg_addr, bus.reg_wdata});
        if (bus.reg_re) re_q.push_back(bus.reg_addr);
    end

    function automatic logic [15:0] we_at(input int i);
        if (i < we_q.size()) return we_q[i];
        return 16'hFFFF;
    endfunction

    function automatic logic [6:0] re_at(input int i);
        if (i < re_q.size()) return re_q[i];
        return 7'h7F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); spi_reset = 1'b1;
        @(negedge clk); spi_reset = 1'b0;
        idle(2);
    endtask

    task automatic send_bit(input logic b, output logic m);
        idle(4);
        m = miso;
        @(negedge clk); mosi_in = b; spi_read = 1'b1;
        @(negedge clk); spi_read = 1'b0;
        idle(4);
        @(negedge clk); spi_write = 1'b1;
        @(negedge clk); spi_write = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int nbits, output logic [7:0] m);
        logic b;
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[7-i], b);
            m = {m[6:0], b};
        end
    endtask

    task automatic clear_logs();
        @(posedge clk);
        we_q.delete();
        re_q.delete();
    endtask

    initial begin
        logic [7:0] m0, m1, m2;

        idle(2);
        chk("rst_miso",   32'(miso), 'h0);
        chk("rst_active", 32'(frame_active), 'h0);
        chk("rst_we",     32'(bus.reg_we), 'h0);
        chk("rst_re",     32'(bus.reg_re), 'h0);
        chk("rst_addr",   32'(bus.reg_addr), 'h0);
        chk("rst_wdata",  32'(bus.reg_wdata), 'h0);
        nrst = 1'b1;
        idle(2);

        // Strobes before any frame start
        send_byte(8'h83, 8, m0);
        send_byte(8'h5A, 8, m1);
        chk("idle_miso0", 32'(m0), 'h00);
        chk("idle_miso1", 32'(m1), 'h00);
        chk("idle_we",    32'(we_q.size()), 'd0);
        chk("idle_re",    32'(re_q.size()), 'd0);
        chk("idle_act",   32'(frame_active), 'h0);

        // Write burst at 0x05
        clear_logs();
        pulse_reset();
        chk("wr_active", 32'(frame_active), 'h1);
        send_byte(8'h05, 8, m0);
        send_byte(8'h11, 8, m1);
        send_byte(8'h22, 8, m2);
        idle(4);
        chk("wr_miso0", 32'(m0), 'hA5);
        chk("wr_miso1", 32'(m1), 'h00);
        chk("wr_miso2", 32'(m2), 'h00);
        chk("wr_cnt",   32'(we_q.size()), 'd2);
        chk("wr_0",     32'(we_at(0)), 'h0511);
        chk("wr_1",     32'(we_at(1)), 'h0622);
        chk("wr_re",    32'(re_q.size()), 'd0);

        // Read burst at 0x03
        clear_logs();
        pulse_reset();
        send_byte(8'h83, 8, m0);
        send_byte(8'h00, 8, m1);
        send_byte(8'h00, 8, m2);
        idle(4);
        chk("rd_miso0", 32'(m0), 'hA5);
        chk("rd_miso1", 32'(m1), 'h43);
        chk("rd_miso2", 32'(m2), 'h44);
        chk("rd_cnt",   32'(re_q.size()), 'd3);
        chk("rd_0",     32'(re_at(0)), 'h03);
        chk("rd_1",     32'(re_at(1)), 'h04);
        chk("rd_2",     32'(re_at(2)), 'h05);
        chk("rd_we",    32'(we_q.size()), 'd0);

        // Address wrap 0x7F -> 0x00
        clear_logs();
        pulse_reset();
        send_byte(8'h7F, 8, m0);
        send_byte(8'hAA, 8, m1);
        send_byte(8'h55, 8, m2);
        idle(4);
        chk("wrap_cnt", 32'(we_q.size()), 'd2);
        chk("wrap_0",   32'(we_at(0)), 'h7FAA);
        chk("wrap_1",   32'(we_at(1)), 'h0055);

        // Aborted frame mid-byte, then a clean write at 0x10
        clear_logs();
        pulse_reset();
        send_byte(8'h20, 8, m0);
        send_byte(8'h33, 8, m1);
        send_byte(8'hCC, 4, m2);
        pulse_reset();
        send_byte(8'h10, 8, m0);
        send_byte(8'h77, 8, m1);
        idle(4);
        chk("abort_miso", 32'(m0), 'hA5);
        chk("abort_cnt",  32'(we_q.size()), 'd2);
        chk("abort_0",    32'(we_at(0)), 'h2033);
        chk("abort_1",    32'(we_at(1)), 'h1077);

        // Async reset in the middle of a read burst
        clear_logs();
        pulse_reset();
        send_byte(8'h83, 8, m0);
        send_byte(8'h00, 3, m1);
        #2 nrst = 1'b0;
        #1;
        chk("arst_miso",   32'(miso), 'h0);
        chk("arst_active", 32'(frame_active), 'h0);
        chk("arst_we",     32'(bus.reg_we), 'h0);
        chk("arst_re",     32'(bus.reg_re), 'h0);
        chk("arst_addr",   32'(bus.reg_addr), 'h0);
        chk("arst_wdata",  32'(bus.reg_wdata), 'h0);
        idle(2);
        nrst = 1'b1;
        clear_logs();
        send_byte(8'h85, 8, m0);
        send_byte(8'h12, 8, m1);
        idle(4);
        chk("post_miso0", 32'(m0), 'h00);
        chk("post_miso1", 32'(m1), 'h00);
        chk("post_we",    32'(we_q.size()), 'd0);
        chk("post_re",    32'(re_q.size()), 'd0);
        chk("post_act",   32'(frame_active), 'h0);
        pulse_reset();
        chk("resume_act",  32'(frame_active), 'h1);
        chk("resume_miso", 32'(miso), 'h1);
        send_byte(8'h01, 8, m0);
        send_byte(8'h5A, 8, m1);
        idle(4);
        chk("resume_cnt", 32'(we_q.size()), 'd1);
        chk("resume_0",   32'(we_at(0)), 'h015A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
